// File: rtl/ann_pkg.sv
// Shared sizing and helpers for the digit-classifier neuron datapath.
package ann_pkg;
    localparam int LANES  = 16;
    localparam int W      = 8;
    localparam int BEATS  = 4;
    localparam int ACC_W  = 24;
    localparam int SHIFT  = 0;
    localparam int PROD_W = 2 * W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STAGES = 2;

    // Lane 0 occupies the most-significant byte of the bus.
    function automatic logic signed [W-1:0] lane_of(input logic [LANES*W-1:0] v, input int i);
        return v[W*(LANES-1-i) +: W];
    endfunction

    function automatic logic [W-1:0] relu_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s < 0)
            return '0;
        else if (s > ACC_W'((1 << W) - 1))
            return {W{1'b1}};
        else
            return s[W-1:0];
    endfunction
endpackage

// File: rtl/node_mac16.sv
// Per-lane signed multipliers (stage 1) feeding a registered adder tree (stage 2).
module node_mac16
    import ann_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [LANES*W-1:0]      a,
    input  logic [LANES*W-1:0]      b,
    output logic signed [ACC_W-1:0] sum
);
    logic [LANES-1:0][PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]      tree_sum;

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst)
                    prod[i] <= '0;
                else if (en)
                    prod[i] <= lane_of(a, i) * lane_of(b, i);
            end
        end
    endgenerate

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < LANES; k++)
            tree_sum = tree_sum + ACC_W'($signed(prod[k]));
    end

    always_ff @(posedge clk) begin
        if (rst)
            sum <= '0;
        else
            sum <= tree_sum;
    end
endmodule

// File: rtl/node_func.sv
// Single neuron: 4-beat MAC of 64 weight/pixel pairs, bias add, ReLU with saturation.
module node_func
    import ann_pkg::*;
(
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    input  logic [W-1:0]       bias,
    input  logic               ready,
    input  logic               clk,
    input  logic               rst,
    output logic [W-1:0]       p
);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]              beat_cnt;
    logic [STAGES:1]                vld_pipe;
    logic [STAGES:1][BEAT_W-1:0]    beat_pipe;
    logic [W-1:0]                   bias_s1, bias_s2;
    logic signed [ACC_W-1:0]        sum, acc, acc_next, node;
    logic                           node_vld;

    node_mac16 u_mac (
        .clk (clk),
        .rst (rst),
        .en  (ready),
        .a   (a),
        .b   (b),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            vld_pipe  <= '0;
            beat_pipe <= '0;
            bias_s1   <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], ready};
            beat_pipe <= {beat_pipe[STAGES-1:1], beat_cnt};
            if (ready) begin
                beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0)
                    bias_s1 <= bias;
            end
        end
    end

    // Bias follows its node down the pipe so the next node's beat 0 can't clobber it.
    always_ff @(posedge clk) begin
        if (rst)
            bias_s2 <= '0;
        else if (vld_pipe[1] && beat_pipe[1] == '0)
            bias_s2 <= bias_s1;
    end

    always_comb begin
        acc_next = ((beat_pipe[STAGES] == '0) ? '0 : acc) + sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            node     <= '0;
            node_vld <= 1'b0;
            p        <= '0;
        end else begin
            node_vld <= vld_pipe[STAGES] && (beat_pipe[STAGES] == LAST);
            if (vld_pipe[STAGES]) begin
                acc <= acc_next;
                if (beat_pipe[STAGES] == LAST)
                    node <= acc_next + ACC_W'($signed(bias_s2));
            end
            if (node_vld)
                p <= relu_sat(node);
        end
    end
endmodule

// File: tb/tb_node_func.sv
// Directed-vector scoreboard bench for node_func: expectations queued at stimulus, checked by a monitor.
module tb_node_func;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ready = 1'b0;
    logic [127:0] a = '0;
    logic [127:0] b = '0;
    logic [7:0]   bias = '0;
    logic [7:0]   p;

    always #5 clk = ~clk;

    node_func dut (
        .a     (a),
        .b     (b),
        .bias  (bias),
        .ready (ready),
        .clk   (clk),
        .rst   (rst),
        .p     (p)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic expect_at(input int c, input logic [7:0] v, input string nm);
        q.push_back('{c, v, nm});
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc)
                $display("FAIL %s: check slot cycle %0d passed (now %0d)", e.name, e.cyc, cyc);
            else if (p !== e.val)
                $display("FAIL %s: cycle %0d p=%02h required %02h", e.name, cyc, p, e.val);
            else
                n_pass++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] bs);
        a     = {16{av}};
        b     = {16{bv}};
        bias  = bs;
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    // Beats 1-3 carry a decoy bias that must be ignored.
    task automatic run_node(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] bs,
                            input logic [7:0] exp_v, input logic [7:0] prev_v,
                            input int gap, input string nm);
        beat(av, bv, bs);
        beat(av, bv, 8'h70);
        repeat (gap) step();
        beat(av, bv, 8'h70);
        expect_at(cyc + 3, prev_v, {nm, "_hold"});
        expect_at(cyc + 4, exp_v, nm);
        beat(av, bv, 8'h70);
    endtask

    initial begin
        expect_at(2, 8'h00, "rst_a");
        expect_at(4, 8'h00, "rst_b");
        repeat (4) step();
        rst = 1'b0;
        expect_at(cyc + 5, 8'h00, "idle_a");
        expect_at(cyc + 10, 8'h00, "idle_b");
        repeat (10) step();

        run_node(8'h01, 8'h01, 8'h00, 8'h40, 8'h00, 0, "basic");
        repeat (5) step();
        run_node(8'h01, 8'h01, 8'h10, 8'h50, 8'h40, 0, "bias");
        run_node(8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'h50, 0, "sat");
        run_node(8'h01, 8'h01, 8'h00, 8'h40, 8'hFF, 0, "b2b");
        run_node(8'hFF, 8'h01, 8'h05, 8'h00, 8'h40, 0, "relu");
        run_node(8'h01, 8'h01, 8'h00, 8'h40, 8'h00, 3, "bubble");
        repeat (5) step();

        beat(8'h01, 8'h01, 8'h00);
        beat(8'h01, 8'h01, 8'h70);
        beat(8'h01, 8'h01, 8'h70);
        rst = 1'b1;
        expect_at(cyc + 1, 8'h00, "rst_mid");
        step();
        rst = 1'b0;
        run_node(8'h02, 8'h01, 8'h00, 8'h80, 8'h00, 0, "fresh");

        repeat (6) step();
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks never reached", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
